display_timing_gen: RTL and testbench
=====================================

DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

Interface
REQ-001 The parameter CORDW SHALL default to 10 and SHALL set the width of the sx and sy coordinates.
REQ-002 The parameter FRAMEW SHALL default to 16 and SHALL set the width of frame_count.
REQ-003 The parameters H_ACTIVE, H_FP, H_SYNC and H_BP SHALL default to 640, 16, 96 and 48, and SHALL set the horizontal active, front porch, sync and back porch lengths in pixels.
REQ-004 The parameters V_ACTIVE, V_FP, V_SYNC and V_BP SHALL default to 480, 11, 2 and 31, and SHALL set the vertical active, front porch, sync and back porch lengths in lines.
REQ-005 The parameters H_POL and V_POL SHALL default to 0; 0 = sync active-low, 1 = sync active-high.
REQ-006 clk_pix  input  1  pixel clock; the only clock.
REQ-007 rst_pix  input  1  reset; synchronous, active-high.
REQ-008 en  input  1  pixel advance enable; acts as a clock enable.
REQ-009 sx  output  CORDW  horizontal position.
REQ-010 sy  output  CORDW  vertical position.
REQ-011 hsync  output  1  horizontal sync, with polarity set by H_POL.
REQ-012 vsync  output  1  vertical sync, with polarity set by V_POL.
REQ-013 de  output  1  data enable; high only in the active region.
REQ-014 line  output  1  one-cycle strobe, high when sx wraps to 0.
REQ-015 frame  output  1  one-cycle strobe, high when (sx,sy) wraps to (0,0).
REQ-016 frame_count  output  FRAMEW  count of completed frames.

Function
REQ-017 Define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-018 Elaboration SHALL fail if H_TOTAL or V_TOTAL exceeds 2^CORDW, or if any length parameter is 0.
REQ-019 All outputs SHALL be flops; no output has a combinational path from en or rst_pix.
REQ-020 In a cycle with en=1:
- sx SHALL increment by 1;
- at sx=H_TOTAL-1, sx SHALL become 0 and sy SHALL increment;
- at sy=V_TOTAL-1 together with sx=H_TOTAL-1, sy SHALL become 0.
REQ-021 In a cycle with en=0, sx, sy, hsync, vsync, de and frame_count SHALL hold, and line and frame SHALL be 0 in the next cycle.
REQ-022 hsync, vsync and de SHALL always correspond to the sx/sy values presented in the same cycle (zero relative latency).
REQ-023 hsync SHALL be asserted (at level H_POL) iff H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC; otherwise it SHALL be at level ~H_POL.
REQ-024 vsync SHALL be asserted (at level V_POL) iff V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC; otherwise it SHALL be at level ~V_POL.
REQ-025 de SHALL be 1 iff sx < H_ACTIVE and sy < V_ACTIVE.
REQ-026 line SHALL be 1 for exactly one clk_pix cycle: the cycle in which sx first presents 0 after a wrap from H_TOTAL-1.
REQ-027 frame SHALL be 1 for exactly one cycle: the cycle in which (0,0) is first presented after a wrap; line SHALL also be 1 in that cycle.
REQ-028 frame_count SHALL increment by 1 in the same cycle that frame asserts, and SHALL wrap modulo 2^FRAMEW.
REQ-029 All counter arithmetic SHALL be unsigned, and no intermediate value SHALL overflow CORDW bits.

Reset
REQ-030 When rst_pix=1 at a clk_pix edge, the following SHALL apply regardless of en:
- sx, sy and frame_count SHALL be 0;
- de SHALL be 1;
- hsync SHALL be ~H_POL and vsync SHALL be ~V_POL;
- line and frame SHALL be 0.
REQ-031 No line or frame strobe SHALL be produced for the post-reset (0,0); the first strobes SHALL occur at the first wrap.
REQ-032 Reset asserted mid-frame SHALL take effect at the next edge and SHALL override any en activity in that cycle.

Verification
REQ-033 Defaults, en=1 continuously after reset -> hsync low for sx 656..751 only; vsync low for sy 491..492 only; de high for sx 0..639 and sy 0..479 only.
REQ-034 Defaults, en=1 -> frame period is 419200 cycles; line period is 800 cycles; frame_count=1 at the first frame strobe and 2 at the second.
REQ-035 Small parameters (H 4/1/2/1, V 3/1/1/1, H_POL=V_POL=1), en=1 -> sx cycles 0..7 and sy cycles 0..5; hsync high at sx 5..6; vsync high at sy 4; frame every 48 cycles.
REQ-036 en toggling 1,0,1,0 around the sx=H_TOTAL-1 wrap -> position holds while en=0; line is high exactly one cycle; no duplicate strobe is produced.
REQ-037 rst_pix pulsed for 1 cycle at sx=300, sy=200 with en=1 -> next cycle sx=0, sy=0, frame=0, frame_count=0, then counting resumes.
REQ-038 FRAMEW=2, run 5 frames -> frame_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/display_timing_gen.sv
// ---------------------------------------------------------------------------
// display_timing_gen
//
// Purpose:
//   Raster timing generator for a pixel-clocked display. It walks a pixel
//   position (sx, sy) over a frame of H_TOTAL x V_TOTAL positions. It also
//   produces the sync pulses, a data-enable for the visible area, one-cycle
//   line/frame strobes and a running count of completed frames.
//
// Ports:
//   clk_pix      in   1       pixel clock (the only clock)
//   rst_pix      in   1       synchronous active-high reset
//   en           in   1       pixel advance enable (clock enable)
//   sx           out  CORDW   horizontal position
//   sy           out  CORDW   vertical position
//   hsync        out  1       horizontal sync, asserted level = H_POL
//   vsync        out  1       vertical sync, asserted level = V_POL
//   de           out  1       data enable, high in the active region only
//   line         out  1       strobe on the cycle sx first shows 0 after a wrap
//   frame        out  1       strobe on the cycle (0,0) first shows after a wrap
//   frame_count  out  FRAMEW  completed frames, wraps modulo 2^FRAMEW
//
// Every output is a flop. hsync/vsync/de are computed from the *next*
// position and registered with it, so they line up with sx/sy in the same
// cycle and have no combinational path from en or rst_pix.
// ---------------------------------------------------------------------------
module display_timing_gen #(
    parameter int CORDW    = 10,
    parameter int FRAMEW   = 16,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 11,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 31,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    input  logic              en,
    output logic [CORDW-1:0]  sx,
    output logic [CORDW-1:0]  sy,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              line,
    output logic              frame,
    output logic [FRAMEW-1:0] frame_count
);

    localparam int     H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam longint CORD_LIMIT = 64'd1 << CORDW;

    // Reject geometries that cannot be represented or are degenerate.
    if (longint'(H_TOTAL) > CORD_LIMIT || longint'(V_TOTAL) > CORD_LIMIT) begin : g_bad_total
        $error("display_timing_gen: H_TOTAL/V_TOTAL exceed 2^CORDW");
    end
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_length
        $error("display_timing_gen: every timing length must be non-zero");
    end

    // All boundaries are strictly below H_TOTAL/V_TOTAL (every porch is at
    // least 1), so they always fit in CORDW bits without overflow.
    localparam logic [CORDW-1:0] H_MAX     = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_MAX     = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT_END = CORDW'(H_ACTIVE);
    localparam logic [CORDW-1:0] V_ACT_END = CORDW'(V_ACTIVE);
    localparam logic [CORDW-1:0] HS_START  = CORDW'(H_ACTIVE + H_FP);
    localparam logic [CORDW-1:0] HS_END    = CORDW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] VS_START  = CORDW'(V_ACTIVE + V_FP);
    localparam logic [CORDW-1:0] VS_END    = CORDW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (H_POL != 0) ? 1'b1 : 1'b0;
    localparam logic VS_ON = (V_POL != 0) ? 1'b1 : 1'b0;

    // Half-open window test lo <= v < hi, unsigned.
    function automatic logic in_window(
        input logic [CORDW-1:0] v,
        input logic [CORDW-1:0] lo,
        input logic [CORDW-1:0] hi
    );
        return (v >= lo) && (v < hi);
    endfunction

    logic [CORDW-1:0]  r_sx;
    logic [CORDW-1:0]  r_sy;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_de;
    logic              r_line;
    logic              r_frame;
    logic [FRAMEW-1:0] r_frame_count;

    logic [CORDW-1:0]  w_sx_next;
    logic [CORDW-1:0]  w_sy_next;
    logic              w_line_next;
    logic              w_frame_next;
    logic              w_hsync_next;
    logic              w_vsync_next;
    logic              w_de_next;

    // Next raster position and wrap strobes for the coming edge.
    always_comb begin
        w_sx_next    = r_sx;
        w_sy_next    = r_sy;
        w_line_next  = 1'b0;
        w_frame_next = 1'b0;
        if (en) begin
            if (r_sx == H_MAX) begin
                w_sx_next   = {CORDW{1'b0}};
                w_line_next = 1'b1;
                if (r_sy == V_MAX) begin
                    w_sy_next    = {CORDW{1'b0}};
                    w_frame_next = 1'b1;
                end else begin
                    w_sy_next = r_sy + CORDW'(1);
                end
            end else begin
                w_sx_next = r_sx + CORDW'(1);
            end
        end else begin
            w_sx_next = r_sx;
            w_sy_next = r_sy;
        end
    end

    // Sync and data-enable levels decoded from the next position so they are
    // registered alongside it.
    always_comb begin
        w_hsync_next = in_window(w_sx_next, HS_START, HS_END) ? HS_ON : ~HS_ON;
        w_vsync_next = in_window(w_sy_next, VS_START, VS_END) ? VS_ON : ~VS_ON;
        w_de_next    = (w_sx_next < H_ACT_END) && (w_sy_next < V_ACT_END);
    end

    // Output registers; reset wins over any enable activity in the same cycle.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_sx          <= {CORDW{1'b0}};
            r_sy          <= {CORDW{1'b0}};
            r_hsync       <= ~HS_ON;
            r_vsync       <= ~VS_ON;
            r_de          <= 1'b1;
            r_line        <= 1'b0;
            r_frame       <= 1'b0;
            r_frame_count <= {FRAMEW{1'b0}};
        end else begin
            r_sx    <= w_sx_next;
            r_sy    <= w_sy_next;
            r_hsync <= w_hsync_next;
            r_vsync <= w_vsync_next;
            r_de    <= w_de_next;
            r_line  <= w_line_next;
            r_frame <= w_frame_next;
            if (w_frame_next) begin
                r_frame_count <= r_frame_count + FRAMEW'(1);
            end else begin
                r_frame_count <= r_frame_count;
            end
        end
    end

    assign sx          = r_sx;
    assign sy          = r_sy;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign line        = r_line;
    assign frame       = r_frame;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_display_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_display_timing_gen
//
// Four instances with different geometries share one clock; each is driven
// on its own en/rst. The reference model counts enabled pixels since reset
// and derives position, sync levels, strobes and frame count from that count
// with plain division/modulo arithmetic.
//   inst0: all defaults
//   inst1: short lines (8/2/4/2), default vertical, H_POL=1
//   inst2: small 4/1/2/1 x 3/1/1/1, both polarities high
//   inst3: same small geometry, FRAMEW=2, H_POL=0, V_POL=1
// ---------------------------------------------------------------------------
module tb_display_timing_gen;

    localparam int P_HA [4] = '{640, 8, 4, 4};
    localparam int P_HF [4] = '{16,  2, 1, 1};
    localparam int P_HS [4] = '{96,  4, 2, 2};
    localparam int P_HB [4] = '{48,  2, 1, 1};
    localparam int P_VA [4] = '{480, 480, 3, 3};
    localparam int P_VF [4] = '{11,  11,  1, 1};
    localparam int P_VS [4] = '{2,   2,   1, 1};
    localparam int P_VB [4] = '{31,  31,  1, 1};
    localparam int P_HP [4] = '{0, 1, 1, 0};
    localparam int P_VP [4] = '{0, 0, 1, 1};
    localparam int P_FW [4] = '{16, 16, 16, 2};

    logic        clk = 1'b0;
    logic        en_a  [4];
    logic        rst_a [4];
    logic [9:0]  o_sx  [4];
    logic [9:0]  o_sy  [4];
    logic        o_hs  [4];
    logic        o_vs  [4];
    logic        o_de  [4];
    logic        o_ln  [4];
    logic        o_fr  [4];
    logic [15:0] o_fc  [3];
    logic [1:0]  o_fc2;
    logic [40:0] obs   [4];

    longint mdl_n  [4];
    logic   mdl_ln [4];
    logic   mdl_fr [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    display_timing_gen u_def (
        .clk_pix(clk), .rst_pix(rst_a[0]), .en(en_a[0]),
        .sx(o_sx[0]), .sy(o_sy[0]), .hsync(o_hs[0]), .vsync(o_vs[0]), .de(o_de[0]),
        .line(o_ln[0]), .frame(o_fr[0]), .frame_count(o_fc[0])
    );

    display_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(4), .H_BP(2), .H_POL(1)
    ) u_tall (
        .clk_pix(clk), .rst_pix(rst_a[1]), .en(en_a[1]),
        .sx(o_sx[1]), .sy(o_sy[1]), .hsync(o_hs[1]), .vsync(o_vs[1]), .de(o_de[1]),
        .line(o_ln[1]), .frame(o_fr[1]), .frame_count(o_fc[1])
    );

    display_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1)
    ) u_small (
        .clk_pix(clk), .rst_pix(rst_a[2]), .en(en_a[2]),
        .sx(o_sx[2]), .sy(o_sy[2]), .hsync(o_hs[2]), .vsync(o_vs[2]), .de(o_de[2]),
        .line(o_ln[2]), .frame(o_fr[2]), .frame_count(o_fc[2])
    );

    display_timing_gen #(
        .FRAMEW(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(0), .V_POL(1)
    ) u_fw2 (
        .clk_pix(clk), .rst_pix(rst_a[3]), .en(en_a[3]),
        .sx(o_sx[3]), .sy(o_sy[3]), .hsync(o_hs[3]), .vsync(o_vs[3]), .de(o_de[3]),
        .line(o_ln[3]), .frame(o_fr[3]), .frame_count(o_fc2)
    );

    // Pack every output of each instance into one comparable vector.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            obs[k] = {o_sx[k], o_sy[k], o_hs[k], o_vs[k], o_de[k], o_ln[k], o_fr[k], o_fc[k]};
        end
        obs[3] = {o_sx[3], o_sy[3], o_hs[3], o_vs[3], o_de[3], o_ln[3], o_fr[3], 14'd0, o_fc2};
    end

    function automatic longint h_total(input int k);
        return longint'(P_HA[k] + P_HF[k] + P_HS[k] + P_HB[k]);
    endfunction

    function automatic longint v_total(input int k);
        return longint'(P_VA[k] + P_VF[k] + P_VS[k] + P_VB[k]);
    endfunction

    // Expected outputs of instance k from its enabled-pixel count.
    function automatic logic [40:0] model_vec(input int k);
        longint ht, vt, n, x, y, fc;
        logic   hs, vs, de;
        ht = h_total(k);
        vt = v_total(k);
        n  = mdl_n[k];
        x  = n % ht;
        y  = (n / ht) % vt;
        fc = (n / (ht * vt)) % (64'd1 << P_FW[k]);
        hs = (x >= P_HA[k] + P_HF[k] && x < P_HA[k] + P_HF[k] + P_HS[k]);
        vs = (y >= P_VA[k] + P_VF[k] && y < P_VA[k] + P_VF[k] + P_VS[k]);
        de = (x < P_HA[k]) && (y < P_VA[k]);
        if (P_HP[k] == 0) hs = ~hs;
        if (P_VP[k] == 0) vs = ~vs;
        return {x[9:0], y[9:0], hs, vs, de, mdl_ln[k], mdl_fr[k], fc[15:0]};
    endfunction

    // One clock: advance every model with the inputs applied, then move to
    // the falling edge where outputs are sampled and new inputs are driven.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (rst_a[k]) begin
                mdl_n[k]  = 0;
                mdl_ln[k] = 1'b0;
                mdl_fr[k] = 1'b0;
            end else if (en_a[k]) begin
                mdl_n[k]  = mdl_n[k] + 1;
                mdl_ln[k] = (mdl_n[k] % h_total(k)) == 0;
                mdl_fr[k] = (mdl_n[k] % (h_total(k) * v_total(k))) == 0;
            end else begin
                mdl_ln[k] = 1'b0;
                mdl_fr[k] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            rst_a[k] = 1'b1;
            en_a[k]  = 1'($urandom_range(0, 1));
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs[k] !== model_vec(k)) begin
                failures++;
                $display("FAIL reset inst%0d actual=%h expected=%h", k, obs[k], model_vec(k));
            end
            rst_a[k] = 1'b0;
            en_a[k]  = 1'b0;
        end
    endtask

    task automatic test_default_random();
        for (int i = 0; i < 3000; i++) begin
            en_a[0] = ($urandom_range(0, 7) != 0);
            tick();
            checks++;
            if (obs[0] !== model_vec(0)) begin
                failures++;
                $display("FAIL default_random cyc%0d actual=%h expected=%h", i, obs[0], model_vec(0));
            end
        end
        en_a[0] = 1'b0;
    endtask

    task automatic test_line_period();
        int gap;
        int found;
        en_a[0] = 1'b1;
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            tick();
            if (o_ln[0] === 1'b1) found = 1;
        end
        gap = 0;
        if (found == 1) begin
            found = 0;
            for (int i = 0; i < 2000 && found == 0; i++) begin
                tick();
                gap++;
                if (o_ln[0] === 1'b1) found = 1;
            end
        end
        checks++;
        if (found == 0 || gap != 800) begin
            failures++;
            $display("FAIL line_period actual=%0d expected=800 (found=%0d)", gap, found);
        end
        en_a[0] = 1'b0;
    endtask

    task automatic test_vertical();
        int nfr;
        int last;
        nfr  = 0;
        last = 0;
        en_a[1] = 1'b1;
        for (int i = 1; i <= 2 * 16 * 524 + 100; i++) begin
            tick();
            checks++;
            if (obs[1] !== model_vec(1)) begin
                failures++;
                $display("FAIL vertical cyc%0d actual=%h expected=%h", i, obs[1], model_vec(1));
            end
            if (o_fr[1] === 1'b1) begin
                nfr++;
                checks++;
                if (o_fc[1] !== 16'(nfr) || (i - last) != 16 * 524) begin
                    failures++;
                    $display("FAIL frame_strobe n%0d actual_fc=%0d period=%0d expected_fc=%0d period=%0d",
                             nfr, o_fc[1], i - last, nfr, 16 * 524);
                end
                last = i;
            end
        end
        checks++;
        if (nfr != 2) begin
            failures++;
            $display("FAIL vertical_frames actual=%0d expected=2", nfr);
        end
        en_a[1] = 1'b0;
    endtask

    task automatic test_small_random();
        for (int i = 0; i < 2000; i++) begin
            en_a[2] = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (obs[2] !== model_vec(2)) begin
                failures++;
                $display("FAIL small_random cyc%0d actual=%h expected=%h", i, obs[2], model_vec(2));
            end
        end
        en_a[2] = 1'b0;
    endtask

    task automatic test_en_toggle();
        logic pat [6];
        int   lines;
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        rst_a[2] = 1'b1;
        tick();
        rst_a[2] = 1'b0;
        en_a[2]  = 1'b1;
        for (int i = 0; i < 64 && (mdl_n[2] % h_total(2)) != 6; i++) begin
            tick();
        end
        checks++;
        if (o_sx[2] !== 10'd6) begin
            failures++;
            $display("FAIL en_toggle_setup actual_sx=%0d expected=6", o_sx[2]);
        end
        lines = 0;
        for (int i = 0; i < 6; i++) begin
            en_a[2] = pat[i];
            tick();
            if (o_ln[2] === 1'b1) lines++;
            checks++;
            if (obs[2] !== model_vec(2)) begin
                failures++;
                $display("FAIL en_toggle step%0d actual=%h expected=%h", i, obs[2], model_vec(2));
            end
        end
        checks++;
        if (lines != 1) begin
            failures++;
            $display("FAIL en_toggle_lines actual=%0d expected=1", lines);
        end
        en_a[2] = 1'b0;
    endtask

    task automatic test_mid_reset();
        rst_a[0] = 1'b1;
        tick();
        rst_a[0] = 1'b0;
        en_a[0]  = 1'b1;
        for (int i = 0; i < 2 * 800 + 300; i++) begin
            tick();
        end
        checks++;
        if (o_sx[0] !== 10'd300 || o_sy[0] !== 10'd2) begin
            failures++;
            $display("FAIL mid_reset_setup actual=%0d,%0d expected=300,2", o_sx[0], o_sy[0]);
        end
        rst_a[0] = 1'b1;
        tick();
        rst_a[0] = 1'b0;
        checks++;
        if (obs[0] !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0}) begin
            failures++;
            $display("FAIL mid_reset actual=%h expected=%h", obs[0],
                     {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0});
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (obs[0] !== model_vec(0)) begin
                failures++;
                $display("FAIL mid_reset_resume cyc%0d actual=%h expected=%h", i, obs[0], model_vec(0));
            end
        end
        en_a[0] = 1'b0;
    endtask

    task automatic test_framew();
        logic [1:0] seen [$];
        logic [1:0] want [5];
        want = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst_a[3] = 1'b1;
        tick();
        rst_a[3] = 1'b0;
        en_a[3]  = 1'b1;
        for (int i = 0; i < 5 * 48; i++) begin
            tick();
            checks++;
            if (obs[3] !== model_vec(3)) begin
                failures++;
                $display("FAIL framew cyc%0d actual=%h expected=%h", i, obs[3], model_vec(3));
            end
            if (o_fr[3] === 1'b1) seen.push_back(o_fc2);
        end
        checks++;
        if (seen.size() != 5) begin
            failures++;
            $display("FAIL framew_count actual=%0d expected=5", seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (seen[i] !== want[i]) begin
                    failures++;
                    $display("FAIL framew_seq idx%0d actual=%0d expected=%0d", i, seen[i], want[i]);
                end
            end
        end
        en_a[3] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            en_a[k]   = 1'b0;
            rst_a[k]  = 1'b1;
            mdl_n[k]  = 0;
            mdl_ln[k] = 1'b0;
            mdl_fr[k] = 1'b0;
        end
        @(negedge clk);
        tick();
        tick();
        test_reset();
        test_default_random();
        test_line_period();
        test_vertical();
        test_small_random();
        test_en_toggle();
        test_mid_reset();
        test_framew();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
